// File: rtl/bcd4_to_bin_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd4_to_bin_ctrl
// Brief    : Serial BCD-to-binary converter; optional BCD_DIGIT_CHECK_EN flags digits > 9
// Revision : 1.0
// ============================================================================
module bcd4_to_bin_ctrl #(
   parameter int NDIGITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  digit,
   input  logic        digit_valid,
   output logic        digit_ready,
   output logic [13:0] result,
   output logic        result_valid,
   input  logic        result_ack,
   output logic        busy,
   output logic        error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] c_last_idx = 3'(NDIGITS - 1);

   state_t      r_state;
   logic [13:0] r_acc;
   logic [2:0]  r_cnt;
   logic        r_ready;
   logic        r_busy;
   logic        r_result_valid;

   logic [13:0] w_acc_next;
   logic        w_bad;
   logic        w_finish;

   // Product is evaluated in 14-bit context, so overflow truncates naturally.
   assign w_acc_next = (r_acc * 14'd10) + {10'd0, digit};

`ifdef BCD_DIGIT_CHECK_EN
   assign w_bad = (digit > 4'd9);
`else
   assign w_bad = 1'b0;
`endif

   assign w_finish = (r_cnt == c_last_idx) || w_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_acc          <= 14'd0;
         r_cnt          <= 3'd0;
         r_ready        <= 1'b0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc   <= 14'd0;
                  r_cnt   <= 3'd0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (digit_valid) begin
                  r_acc <= w_bad ? 14'd0 : w_acc_next;
                  r_cnt <= r_cnt + 3'd1;
                  if (w_finish) begin
                     r_ready        <= 1'b0;
                     r_result_valid <= 1'b1;
                     r_state        <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (result_ack) begin
                  r_result_valid <= 1'b0;
                  r_busy         <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            default: begin
               r_ready        <= 1'b0;
               r_busy         <= 1'b0;
               r_result_valid <= 1'b0;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

`ifdef BCD_DIGIT_CHECK_EN
   logic r_error;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_error <= 1'b0;
      end else if ((r_state == S_IDLE) && start) begin
         r_error <= 1'b0;
      end else if ((r_state == S_ACCUM) && digit_valid && w_bad) begin
         r_error <= 1'b1;
      end
   end

   assign error = r_error;
`else
   assign error = 1'b0;
`endif

   assign digit_ready  = r_ready;
   assign result       = r_acc;
   assign result_valid = r_result_valid;
   assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bcd4_to_bin_ctrl.sv
`default_nettype none
// Testbench for bcd4_to_bin_ctrl: directed table, hand sequences and randomized conversions.
module tb_bcd4_to_bin_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start = 1'b0;
   logic [3:0]  digit = 4'd0;
   logic        digit_valid = 1'b0;
   logic        result_ack = 1'b0;
   logic        digit_ready;
   logic [13:0] result;
   logic        result_valid;
   logic        busy;
   logic        error;

   logic        start2 = 1'b0;
   logic [3:0]  digit2 = 4'd0;
   logic        digit_valid2 = 1'b0;
   logic        result_ack2 = 1'b0;
   logic        digit_ready2;
   logic [13:0] result2;
   logic        result_valid2;
   logic        busy2;
   logic        error2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd4_to_bin_ctrl #(.NDIGITS(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .digit(digit),
      .digit_valid(digit_valid), .digit_ready(digit_ready), .result(result),
      .result_valid(result_valid), .result_ack(result_ack), .busy(busy), .error(error)
   );

   bcd4_to_bin_ctrl #(.NDIGITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .digit(digit2),
      .digit_valid(digit_valid2), .digit_ready(digit_ready2), .result(result2),
      .result_valid(result_valid2), .result_ack(result_ack2), .busy(busy2), .error(error2)
   );

   typedef struct {
      logic [15:0] digits;
      int          gap;
      int          ack_dly;
      logic [13:0] exp_res;
      logic        exp_err;
      int          used;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: decimal accumulation modulo 2^14, stopping at a bad digit when checking is on.
   function automatic void model(input logic [15:0] dg, input int nd,
                                 output logic [13:0] res, output logic err, output int used);
      int acc;
      int d;
      acc  = 0;
      err  = 1'b0;
      used = nd;
      for (int i = 0; i < nd; i++) begin
         d = int'(dg[15-4*i -: 4]);
`ifdef BCD_DIGIT_CHECK_EN
         if (d > 9) begin
            err  = 1'b1;
            acc  = 0;
            used = i + 1;
            break;
         end
`endif
         acc = (acc * 10 + d) % 16384;
      end
      res = 14'(acc);
   endfunction

   task automatic run_conv(input logic [15:0] dg, input int gap, input int ack_dly,
                           input logic [13:0] er, input logic ee, input int used,
                           input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, ":busy_start"}, 32'(busy), 32'd1);
      chk({tag, ":ready_start"}, 32'(digit_ready), 32'd1);
      chk({tag, ":err_cleared"}, 32'(error), 32'd0);
      for (int i = 0; i < used; i++) begin
         repeat (gap) begin
            tick();
            chk({tag, ":ready_gap"}, 32'(digit_ready), 32'd1);
         end
         digit       = dg[15-4*i -: 4];
         digit_valid = 1'b1;
         tick();
         digit_valid = 1'b0;
         chk({tag, ":rv_after_digit"}, 32'(result_valid), (i == used - 1) ? 32'd1 : 32'd0);
      end
      chk({tag, ":ready_done"}, 32'(digit_ready), 32'd0);
      chk({tag, ":result"}, 32'(result), 32'(er));
      chk({tag, ":error"}, 32'(error), 32'(ee));
      repeat (ack_dly) begin
         tick();
         chk({tag, ":rv_hold"}, 32'(result_valid), 32'd1);
         chk({tag, ":result_hold"}, 32'(result), 32'(er));
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      chk({tag, ":rv_after_ack"}, 32'(result_valid), 32'd0);
      chk({tag, ":busy_after_ack"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl[5];
      logic [15:0] rd;
      logic [13:0] mres;
      logic        merr;
      int          mused;

      tbl[0] = '{16'h1234, 0, 0, 14'd1234, 1'b0, 4};
      tbl[1] = '{16'h9999, 3, 2, 14'd9999, 1'b0, 4};
      tbl[2] = '{16'h0000, 1, 0, 14'd0,    1'b0, 4};
`ifdef BCD_DIGIT_CHECK_EN
      tbl[3] = '{16'h3C00, 0, 1, 14'd0,    1'b1, 2};
      tbl[4] = '{16'hFFFF, 0, 0, 14'd0,    1'b1, 1};
`else
      tbl[3] = '{16'h3C00, 0, 1, 14'd4200, 1'b0, 4};
      tbl[4] = '{16'hFFFF, 0, 0, 14'd281,  1'b0, 4};
`endif

      // Reset state
      repeat (2) tick();
      chk("rst:busy", 32'(busy), 32'd0);
      chk("rst:ready", 32'(digit_ready), 32'd0);
      chk("rst:result", 32'(result), 32'd0);
      chk("rst:rv", 32'(result_valid), 32'd0);
      chk("rst:error", 32'(error), 32'd0);
      chk("rst:busy2", 32'(busy2), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         run_conv(tbl[v].digits, tbl[v].gap, tbl[v].ack_dly, tbl[v].exp_res,
                  tbl[v].exp_err, tbl[v].used, $sformatf("vec%0d", v));
      end

      // Two-digit instance holding its result while ack is withheld
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      digit2 = 4'd4;
      digit_valid2 = 1'b1;
      tick();
      chk("nd2:rv_early", 32'(result_valid2), 32'd0);
      digit2 = 4'd2;
      tick();
      digit_valid2 = 1'b0;
      chk("nd2:rv", 32'(result_valid2), 32'd1);
      chk("nd2:result", 32'(result2), 32'd42);
      repeat (5) begin
         tick();
         chk("nd2:result_hold", 32'(result2), 32'd42);
         chk("nd2:rv_hold", 32'(result_valid2), 32'd1);
      end
      result_ack2 = 1'b1;
      tick();
      result_ack2 = 1'b0;
      chk("nd2:busy_after_ack", 32'(busy2), 32'd0);
      chk("nd2:rv_after_ack", 32'(result_valid2), 32'd0);

      // Asynchronous reset mid-conversion, then a fresh conversion
      start = 1'b1;
      tick();
      start = 1'b0;
      digit_valid = 1'b1;
      digit = 4'd5;
      tick();
      digit = 4'd6;
      tick();
      digit_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst:busy", 32'(busy), 32'd0);
      chk("arst:ready", 32'(digit_ready), 32'd0);
      chk("arst:result", 32'(result), 32'd0);
      chk("arst:rv", 32'(result_valid), 32'd0);
      digit = 4'd9;
      digit_valid = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("arst:no_accept_ready", 32'(digit_ready), 32'd0);
         chk("arst:no_accept_busy", 32'(busy), 32'd0);
         chk("arst:no_rv", 32'(result_valid), 32'd0);
         chk("arst:result_zero", 32'(result), 32'd0);
      end
      digit_valid = 1'b0;
      run_conv(16'h0007, 0, 0, 14'd7, 1'b0, 4, "restart");

      // start ignored in ACCUM; start+ack in DONE only returns to IDLE
      start = 1'b1;
      tick();
      digit = 4'd1;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
      tick();
      chk("ign:busy", 32'(busy), 32'd1);
      chk("ign:result_kept", 32'(result), 32'd1);
      digit_valid = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         digit = 4'(i);
         tick();
      end
      digit_valid = 1'b0;
      chk("ign:rv", 32'(result_valid), 32'd1);
      chk("ign:result", 32'(result), 32'd1234);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      chk("ign:idle_busy", 32'(busy), 32'd0);
      chk("ign:idle_rv", 32'(result_valid), 32'd0);
      chk("ign:idle_result", 32'(result), 32'd1234);
      start = 1'b0;
      tick();
      chk("ign:still_idle", 32'(busy), 32'd0);

      // result_ack ignored in ACCUM
      start = 1'b1;
      tick();
      start = 1'b0;
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      chk("ackign:busy", 32'(busy), 32'd1);
      chk("ackign:ready", 32'(digit_ready), 32'd1);
      digit_valid = 1'b1;
      for (int i = 5; i <= 8; i++) begin
         digit = 4'(i);
         tick();
      end
      digit_valid = 1'b0;
      chk("ackign:result", 32'(result), 32'd5678);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;

      // Randomized conversions against the reference model
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 4; i++) begin
            rd[15-4*i -: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
         end
         model(rd, 4, mres, merr, mused);
         run_conv(rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                  mres, merr, mused, $sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd4_to_bin_ctrl.md
BCD4_TO_BIN_CTRL -- requirements
Module: bcd4_to_bin_ctrl

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 4, giving the number of BCD digits per conversion (legal 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a conversion, sampled in IDLE only.
REQ-005 The block SHALL have port digit, input, 4 bits: BCD digit, most significant digit first.
REQ-006 The block SHALL have port digit_valid, input, 1 bit: digit is presented.
REQ-007 The block SHALL have port digit_ready, output, 1 bit: block accepts a digit this cycle.
REQ-008 The block SHALL have port result, output, 14 bits: binary value of the accumulated digits.
REQ-009 The block SHALL have port result_valid, output, 1 bit: result is final and held.
REQ-010 The block SHALL have port result_ack, input, 1 bit: consumer has taken the result.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port error, output, 1 bit: invalid digit seen (tied 0 without BCD_DIGIT_CHECK_EN).

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-014 In IDLE with start=1, the FSM SHALL clear the accumulator, digit counter and error, then enter ACCUM on the next edge.
REQ-015 digit_ready SHALL be 1 only in ACCUM; a digit is accepted on a rising edge where digit_valid && digit_ready.
REQ-016 On each accepted digit, the accumulator SHALL update to acc*10 + digit, truncated to 14 bits, and the counter SHALL increment.
REQ-017 When the NDIGITS-th digit is accepted, the FSM SHALL enter DONE, and result_valid SHALL be 1 in the following cycle (one-cycle latency from the last accepted digit).
REQ-018 In DONE, result and error SHALL remain stable until result_ack=1; on that edge the FSM SHALL return to IDLE and result_valid SHALL fall.
REQ-019 Outside IDLE, start SHALL be ignored; a conversion in progress is never restarted.
REQ-020 Outside DONE, result_ack SHALL be ignored.
REQ-021 In ACCUM with digit_valid=0, the state SHALL hold indefinitely, with no timeout.
REQ-022 With start=1 and result_ack=1 in the same DONE cycle, the FSM SHALL go to IDLE only; start needs a further IDLE cycle to take effect.
REQ-023 result SHALL show the live accumulator at all times; it is meaningful only while result_valid=1.
REQ-024 For legal digits, the maximum result SHALL be 9999 (NDIGITS=4), which fits 14 bits without truncation.

Reset
REQ-025 On rst_n=0, the block SHALL immediately, without waiting for clk, force state=IDLE, accumulator=0, counter=0, result=0, result_valid=0, digit_ready=0, busy=0 and error=0.
REQ-026 Reset asserted mid-conversion SHALL discard partial results, and no result_valid pulse SHALL follow.
REQ-027 After rst_n rises, the block SHALL need a fresh start before it accepts any digit.

Configuration
REQ-028 With macro BCD_DIGIT_CHECK_EN defined, an accepted digit > 9 SHALL set error=1, force result=0 and send the FSM to DONE immediately, ending the conversion early with result_valid=1.
REQ-029 Without BCD_DIGIT_CHECK_EN, a digit > 9 SHALL be accumulated arithmetically per REQ-016, with 14-bit truncation, and error SHALL be constant 0.

Verification
REQ-030 Reset, start, then digits 1,2,3,4 on consecutive cycles -> result_valid=1 one cycle after digit 4, result=1234, error=0.
REQ-031 Digits 9,9,9,9 with digit_valid gaps of 3 cycles between them -> result=9999 (14'h270F), and digit_ready is high throughout ACCUM.
REQ-032 NDIGITS=2, digits 4,2, with result_ack held low for 5 cycles -> result=42 held stable; after result_ack, busy=0 on the next cycle.
REQ-033 Assert rst_n=0 after 2 of 4 digits, then restart with digits 0,0,0,7 -> no result_valid before restart, final result=7.
REQ-034 With BCD_DIGIT_CHECK_EN defined, digits 3,12 -> DONE after the second digit, error=1, result=0; without the macro, digits 3,12,0,0 -> result=4200, error=0.
REQ-035 start pulsed during ACCUM, and start together with result_ack in DONE -> neither restarts a conversion, and result is unchanged until IDLE.
